// File: rtl/graph_view_ctrl.sv
// Button-driven view configuration for the graph/bar pixel datapath; edits land in a pending copy
// and reach the live outputs only on a vsync falling edge. Optional bar auto-sweep: AUTO_SWEEP_EN.
module graph_view_ctrl #(
    parameter int H_CENTER  = 400,
    parameter int V_CENTER  = 240,
    parameter int H_MAX     = 799,
    parameter int V_MAX     = 479,
    parameter int PAN_STEP  = 10,
    parameter int BAR_INIT  = 250,
    parameter int BAR_STEP  = 50,
    parameter int BAR_MAX   = 800,
    parameter int ZOOM_MAX  = 4,
    parameter int NUM_FUNCS = 3
`ifdef AUTO_SWEEP_EN
    ,
    parameter int SWEEP_FRAMES = 30
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        btn_mode,
    input  logic        btn_func,
    input  logic        btn_zoom_in,
    input  logic        btn_zoom_out,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_home,
    input  logic        btn_bar,
    output logic        graph_mode,
    output logic [1:0]  func_sel,
    output logic [2:0]  zoom_shift,
    output logic [11:0] x_origin,
    output logic [11:0] y_origin,
    output logic [11:0] bar_len,
    output logic        cfg_update,
    output logic        pending
);

    typedef enum logic [1:0] {IDLE, DIRTY, COMMIT} state_t;
    state_t state, state_nxt;

    logic        vsync_q, frame_start;
    logic        p_graph, n_graph;
    logic [1:0]  p_func, n_func;
    logic [2:0]  p_zoom, n_zoom;
    logic [11:0] p_x, n_x, p_y, n_y, p_bar, n_bar, bar_fin;
    logic [12:0] x_w, y_w;
    logic        press, sweep_hit;

    function automatic logic [11:0] bar_next(input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, b} + 13'(BAR_STEP);
        return (s > 13'(BAR_MAX)) ? 12'd0 : s[11:0];
    endfunction

    assign frame_start = vsync_q & ~vsync;
    assign pending     = (state == DIRTY);

    // Home beats mode beats everything else; opposing pan/zoom pairs cancel and count as no press.
    always_comb begin
        n_graph = p_graph;
        n_func  = p_func;
        n_zoom  = p_zoom;
        n_x     = p_x;
        n_y     = p_y;
        n_bar   = p_bar;
        x_w     = 13'd0;
        y_w     = 13'd0;
        press   = 1'b0;
        if (btn_home && p_graph) begin
            n_x   = 12'(H_CENTER);
            n_y   = 12'(V_CENTER);
            n_zoom = 3'd0;
            press = 1'b1;
        end else if (btn_mode) begin
            n_graph = ~p_graph;
            press   = 1'b1;
        end else if (p_graph) begin
            if (btn_func) begin
                n_func = (p_func == 2'(NUM_FUNCS - 1)) ? 2'd0 : p_func + 2'd1;
                press  = 1'b1;
            end
            if (btn_zoom_in && !btn_zoom_out) begin
                n_zoom = (p_zoom < 3'(ZOOM_MAX)) ? p_zoom + 3'd1 : p_zoom;
                press  = 1'b1;
            end else if (btn_zoom_out && !btn_zoom_in) begin
                n_zoom = (p_zoom != 3'd0) ? p_zoom - 3'd1 : p_zoom;
                press  = 1'b1;
            end
            if (btn_left && !btn_right) begin
                x_w   = {1'b0, p_x} - 13'(PAN_STEP);
                n_x   = x_w[12] ? 12'd0 : x_w[11:0];
                press = 1'b1;
            end else if (btn_right && !btn_left) begin
                x_w   = {1'b0, p_x} + 13'(PAN_STEP);
                n_x   = (x_w > 13'(H_MAX)) ? 12'(H_MAX) : x_w[11:0];
                press = 1'b1;
            end
            if (btn_up && !btn_down) begin
                y_w   = {1'b0, p_y} - 13'(PAN_STEP);
                n_y   = y_w[12] ? 12'd0 : y_w[11:0];
                press = 1'b1;
            end else if (btn_down && !btn_up) begin
                y_w   = {1'b0, p_y} + 13'(PAN_STEP);
                n_y   = (y_w > 13'(V_MAX)) ? 12'(V_MAX) : y_w[11:0];
                press = 1'b1;
            end
        end else if (btn_bar) begin
            n_bar = bar_next(p_bar);
            press = 1'b1;
        end
    end

`ifdef AUTO_SWEEP_EN
    logic       bar_press;
    logic [7:0] sweep_cnt;
    assign bar_press = btn_bar & ~p_graph & ~btn_mode;
    assign sweep_hit = frame_start & ~p_graph & (sweep_cnt == 8'(SWEEP_FRAMES - 1));
    assign bar_fin   = (sweep_hit && !bar_press) ? bar_next(p_bar) : n_bar;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       sweep_cnt <= 8'd0;
        else if (bar_press || sweep_hit) sweep_cnt <= 8'd0;
        else if (frame_start && !p_graph) sweep_cnt <= sweep_cnt + 8'd1;
    end
`else
    assign sweep_hit = 1'b0;
    assign bar_fin   = n_bar;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sweep_hit) state_nxt = COMMIT;
                     else if (press) state_nxt = DIRTY;
            DIRTY:   if (frame_start) state_nxt = COMMIT;
            COMMIT:  state_nxt = (press || sweep_hit) ? DIRTY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Live copies take the pending value held before this cycle's presses are folded in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vsync_q    <= 1'b1;
            p_graph    <= 1'b0;
            p_func     <= 2'd0;
            p_zoom     <= 3'd0;
            p_x        <= 12'(H_CENTER);
            p_y        <= 12'(V_CENTER);
            p_bar      <= 12'(BAR_INIT);
            graph_mode <= 1'b0;
            func_sel   <= 2'd0;
            zoom_shift <= 3'd0;
            x_origin   <= 12'(H_CENTER);
            y_origin   <= 12'(V_CENTER);
            bar_len    <= 12'(BAR_INIT);
            cfg_update <= 1'b0;
        end else begin
            state      <= state_nxt;
            vsync_q    <= vsync;
            p_graph    <= n_graph;
            p_func     <= n_func;
            p_zoom     <= n_zoom;
            p_x        <= n_x;
            p_y        <= n_y;
            p_bar      <= bar_fin;
            cfg_update <= (state == COMMIT);
            if (state == COMMIT) begin
                graph_mode <= p_graph;
                func_sel   <= p_func;
                zoom_shift <= p_zoom;
                x_origin   <= p_x;
                y_origin   <= p_y;
                bar_len    <= p_bar;
            end
        end
    end

endmodule
